// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared parameters and state encoding for the serial adder controller
package adder_ctrl_pkg;

   localparam int SLICE_W_DEF    = 8;
   localparam int NUM_SLICES_DEF = 4;
   localparam int W_DEF          = SLICE_W_DEF * NUM_SLICES_DEF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Slice counter width; a single-slice build still needs one bit.
   function automatic int idx_width(input int num_slices);
      return (num_slices > 1) ? $clog2(num_slices) : 1;
   endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational ripple-carry adder slice
module add_slice #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   logic [WIDTH:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[WIDTH];

endmodule

// File: rtl/adder_serial_ctrl.sv
// rtl/adder_serial_ctrl.sv - multi-cycle add/subtract sequencer time-sharing one adder slice
module adder_serial_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter  int SLICE_W    = SLICE_W_DEF,
   parameter  int NUM_SLICES = NUM_SLICES_DEF,
   localparam int W          = SLICE_W * NUM_SLICES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int              IDX_W    = idx_width(NUM_SLICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   state_t             state;
   logic [W-1:0]       a_sh;
   logic [W-1:0]       b_sh;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic [SLICE_W-1:0] s;
   logic               c_next;
   logic [W-1:0]       sum_shift;
   logic               last_ovf;

   add_slice #(.WIDTH(SLICE_W)) u_slice (
      .a  (a_sh[SLICE_W-1:0]),
      .b  (b_sh[SLICE_W-1:0]),
      .ci (carry),
      .s  (s),
      .co (c_next)
   );

   assign in_ready  = (state == IDLE) && !rst;
   // New slice enters at the top so the LSB slice ends up at the bottom after the last pass.
   assign sum_shift = (sum >> SLICE_W) | (W'(s) << (W - SLICE_W));
   // b_sh already holds the post-invert operand, so its MSB is the effective B sign.
   assign last_ovf  = (a_sh[SLICE_W-1] == b_sh[SLICE_W-1]) && (s[SLICE_W-1] != a_sh[SLICE_W-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= op_a;
                  b_sh  <= sub ? ~op_b : op_b;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> SLICE_W;
               b_sh  <= b_sh >> SLICE_W;
               sum   <= sum_shift;
               carry <= c_next;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  cout      <= c_next;
                  ovf       <= last_ovf;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// tb/tb_adder_serial_ctrl.sv - self-checking bench for adder_serial_ctrl
module tb_adder_serial_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   adder_serial_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic        s;
      logic [31:0] es;
      logic        ec;
      logic        eo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact integer arithmetic, overflow as an out-of-range signed result.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic s);
      longint      sa, sb, r;
      longint      lim;
      logic [32:0] u;
      logic [31:0] res;
      logic        co;
      lim = 64'sh7FFF_FFFF;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      if (!s) begin
         u   = {1'b0, a} + {1'b0, b} + 33'(c);
         res = u[31:0];
         co  = u[32];
         r   = sa + sb + longint'(c);
      end else begin
         res = a - b;
         co  = (a >= b);
         r   = sa - sb;
      end
      return {(r > lim) || (r < -lim - 1), co, res};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                         output logic [31:0] rs, output logic rc, output logic ro, output int lat);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = sum; rc = cout; ro = ovf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [31:0] rs;
   logic        rc, ro;
   int          lat;
   logic [33:0] m;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_sum", sum, 0);
      check("reset_cout", cout, 0);
      check("reset_ovf", ovf, 0);
      rst = 1'b0; #1;
      check("post_reset_in_ready", in_ready, 1);

      vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
      vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
      vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
      vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
      vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
      vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, rs, rc, ro, lat);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_sum", i), rs, vecs[i].es);
         check($sformatf("vec%0d_cout", i), rc, vecs[i].ec);
         check($sformatf("vec%0d_ovf", i), ro, vecs[i].eo);
         check($sformatf("vec%0d_idle_valid", i), out_valid, 0);
         check($sformatf("vec%0d_idle_ready", i), in_ready, 1);
      end

      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         logic        c, s;
         a = $urandom; b = $urandom; c = 1'($urandom); s = 1'($urandom);
         case ($urandom_range(0, 4))
            0: a = 32'h7FFF_FFFF;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         m = model(a, b, c, s);
         run_op(a, b, c, s, rs, rc, ro, lat);
         check($sformatf("rnd%0d_latency", i), lat, 4);
         check($sformatf("rnd%0d_sum", i), rs, m[31:0]);
         check($sformatf("rnd%0d_cout", i), rc, m[32]);
         check($sformatf("rnd%0d_ovf", i), ro, m[33]);
      end

      // Backpressure in DONE with competing requests
      op_a = 32'h0000_00FF; op_b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
         @(posedge clk); #1;
         check($sformatf("bp%0d_out_valid", i), out_valid, 1);
         check($sformatf("bp%0d_sum", i), sum, 32'h0000_0100);
         check($sformatf("bp%0d_cout", i), cout, 0);
         check($sformatf("bp%0d_ovf", i), ovf, 0);
         check($sformatf("bp%0d_in_ready", i), in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_out_valid", out_valid, 0);
      repeat (6) @(posedge clk);
      #1;
      check("bp_no_queued_op", out_valid, 0);

      // Reset two cycles into RUN
      op_a = 32'hFFFF_FFFF; op_b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      check("midrst_release_in_ready", in_ready, 1);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, rs, rc, ro, lat);
      check("midrst_fresh_sum", rs, 32'h2345_6789);
      check("midrst_fresh_cout", rc, 0);
      check("midrst_fresh_ovf", ro, 0);

      // Back-to-back with in_valid and out_ready held high
      begin
         logic [31:0] ba[3], bb[3];
         logic        bs[3];
         int          acc_cyc[$];
         logic [33:0] res_q[$];
         int          cyc, k;
         for (int i = 0; i < 3; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bs[i] = 1'($urandom);
         end
         cyc = 0; k = 0;
         op_a = ba[0]; op_b = bb[0]; sub = bs[0]; cin = 1'b1;
         in_valid = 1'b1; out_ready = 1'b1;
         for (int n = 0; n < 60 && res_q.size() < 3; n++) begin
            logic acc, done;
            acc  = in_valid && in_ready;
            done = out_valid && out_ready;
            if (done) res_q.push_back({ovf, cout, sum});
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
               acc_cyc.push_back(cyc);
               k++;
               if (k < 3) begin
                  op_a = ba[k]; op_b = bb[k]; sub = bs[k];
               end else begin
                  in_valid = 1'b0;
               end
            end
         end
         in_valid = 1'b0; out_ready = 1'b0;
         check("b2b_accepts", acc_cyc.size(), 3);
         check("b2b_results", res_q.size(), 3);
         for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
         for (int i = 0; i < res_q.size(); i++)
            check($sformatf("b2b_result%0d", i), res_q[i], model(ba[i], bb[i], 1'b1, bs[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
